t07_fetch_unit: RTL and testbench

T07_FETCH_UNIT -- requirements
Module: t07_fetch_unit

---
 rtl/t07_cpu_pkg.sv | 30 +++
 rtl/t07_fetch_unit.sv | 94 +++++++++
 tb/tb_t07_fetch_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/t07_cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, the canonical NOP and base opcodes.
package t07_cpu_pkg;

  // Fetch unit control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Base RV32I major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Word-align an address by clearing the byte offset
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/t07_fetch_unit.sv
// Instruction fetch unit: requests one word at a time from memory, holds it
// for the decoder until consumed, and restarts from a new address on redirect.
module t07_fetch_unit
  import t07_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  input  logic        memAck,
  input  logic [31:0] memData,
  output logic        memReq,
  output logic [31:0] memAddr,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic [31:0] instrPC,
  output logic [6:0]  Op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  fetch_state_t state;
  logic [31:0]  fetchPC;

  // Request address is the live fetch pointer; it only moves on ack or redirect
  assign memAddr = fetchPC;

  // Decode field slices of the held instruction
  always_comb begin
    Op     = instr[6:0];
    rd     = instr[11:7];
    funct3 = instr[14:12];
    rs1    = instr[19:15];
    rs2    = instr[24:20];
    funct7 = instr[31:25];
  end

  // FSM and datapath; memReq is registered alongside the state so it is high
  // exactly in FETCH. Redirect overrides every state, including a same-edge ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetchPC    <= RESET_PC;
      instr      <= NOP;
      instrPC    <= RESET_PC;
      instrValid <= 1'b0;
      memReq     <= 1'b0;
    end else if (redirect) begin
      fetchPC    <= word_align(redirectPC);
      instr      <= NOP;
      instrValid <= 1'b0;
      state      <= en ? FETCH : IDLE;
      memReq     <= en;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state  <= FETCH;
            memReq <= 1'b1;
          end
        end
        FETCH: begin
          if (memAck) begin
            instr      <= memData;
            instrPC    <= fetchPC;
            instrValid <= 1'b1;
            fetchPC    <= fetchPC + 32'd4;
            state      <= HOLD;
            memReq     <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instrValid <= 1'b0;
            state      <= en ? FETCH : IDLE;
            memReq     <= en;
          end
        end
        default: begin
          state  <= IDLE;
          memReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t07_fetch_unit.sv
// Bench for t07_fetch_unit: two instances (default and wrapping RESET_PC)
// share stimulus; an abstract model is compared every cycle, and literal
// expectations pin the key scenarios.
module tb_t07_fetch_unit;

  localparam logic [31:0] NOPW = 32'h0000_0013;
  localparam logic [31:0] RPB  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, stall = 1'b0, redirect = 1'b0, memAck = 1'b0;
  logic [31:0] redirectPC = '0, memData = '0;

  logic        memReq_a, instrValid_a, memReq_b, instrValid_b;
  logic [31:0] memAddr_a, instr_a, instrPC_a, memAddr_b, instr_b, instrPC_b;
  logic [6:0]  Op_a, funct7_a, Op_b, funct7_b;
  logic [2:0]  funct3_a, funct3_b;
  logic [4:0]  rs1_a, rs2_a, rd_a, rs1_b, rs2_b, rd_b;

  t07_fetch_unit dut_a (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .redirect(redirect),
    .redirectPC(redirectPC), .memAck(memAck), .memData(memData),
    .memReq(memReq_a), .memAddr(memAddr_a), .instr(instr_a),
    .instrValid(instrValid_a), .instrPC(instrPC_a), .Op(Op_a),
    .funct3(funct3_a), .funct7(funct7_a), .rs1(rs1_a), .rs2(rs2_a), .rd(rd_a)
  );

  t07_fetch_unit #(.RESET_PC(RPB)) dut_b (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .redirect(redirect),
    .redirectPC(redirectPC), .memAck(memAck), .memData(memData),
    .memReq(memReq_b), .memAddr(memAddr_b), .instr(instr_b),
    .instrValid(instrValid_b), .instrPC(instrPC_b), .Op(Op_b),
    .funct3(funct3_b), .funct7(funct7_b), .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int npass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Abstract model: "waiting" = a request is outstanding, "holding" = a word
  // is presented to decode. Neither set means parked.
  bit          m_wait[2], m_hold[2];
  logic [31:0] m_pc[2], m_ins[2], m_ipc[2];
  logic [31:0] m_rp[2];
  initial begin
    m_rp[0] = 32'h0;
    m_rp[1] = RPB;
  end

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_wait[i] = 1'b0; m_hold[i] = 1'b0;
        m_pc[i] = m_rp[i]; m_ins[i] = NOPW; m_ipc[i] = m_rp[i];
      end else if (redirect) begin
        m_pc[i] = redirectPC & 32'hFFFF_FFFC;
        m_ins[i] = NOPW; m_hold[i] = 1'b0; m_wait[i] = en;
      end else if (m_wait[i]) begin
        if (memAck) begin
          m_ins[i] = memData; m_ipc[i] = m_pc[i]; m_pc[i] = m_pc[i] + 32'd4;
          m_hold[i] = 1'b1; m_wait[i] = 1'b0;
        end
      end else if (m_hold[i]) begin
        if (!stall) begin
          m_hold[i] = 1'b0; m_wait[i] = en;
        end
      end else begin
        m_wait[i] = en;
      end
    end
  end

  task automatic cmp_inst(input int i, input logic req, input logic [31:0] addr,
                          input logic [31:0] ins, input logic vld, input logic [31:0] ipc,
                          input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd);
    string p;
    p = (i == 0) ? "a." : "b.";
    check({p, "memReq"},     {31'b0, req}, {31'b0, m_wait[i]});
    check({p, "memAddr"},    addr, m_pc[i]);
    check({p, "instr"},      ins, m_ins[i]);
    check({p, "instrValid"}, {31'b0, vld}, {31'b0, m_hold[i]});
    check({p, "instrPC"},    ipc, m_ipc[i]);
    check({p, "Op"},         {25'b0, op}, {25'b0, m_ins[i][6:0]});
    check({p, "funct3"},     {29'b0, f3}, {29'b0, m_ins[i][14:12]});
    check({p, "funct7"},     {25'b0, f7}, {25'b0, m_ins[i][31:25]});
    check({p, "rs1"},        {27'b0, r1}, {27'b0, m_ins[i][19:15]});
    check({p, "rs2"},        {27'b0, r2}, {27'b0, m_ins[i][24:20]});
    check({p, "rd"},         {27'b0, rdd}, {27'b0, m_ins[i][11:7]});
  endtask

  // Per-cycle model comparison, sampled away from the active edge
  always @(negedge clk) begin
    cmp_inst(0, memReq_a, memAddr_a, instr_a, instrValid_a, instrPC_a,
             Op_a, funct3_a, funct7_a, rs1_a, rs2_a, rd_a);
    cmp_inst(1, memReq_b, memAddr_b, instr_b, instrValid_b, instrPC_b,
             Op_b, funct3_b, funct7_b, rs1_b, rs2_b, rd_b);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [31:0] tbl [4];

  initial begin
    tbl[0] = 32'h0010_0113; tbl[1] = 32'h0020_8193;
    tbl[2] = 32'h4030_5233; tbl[3] = 32'h0041_2023;

    #1 rst = 1'b1;
    tick();
    check("rst_memReq", {31'b0, memReq_a}, 32'd0);
    check("rst_instr", instr_a, NOPW);
    check("rst_valid", {31'b0, instrValid_a}, 32'd0);
    check("rst_addr_b", memAddr_b, 32'hFFFF_FFFC);
    check("rst_ipc_b", instrPC_b, 32'hFFFF_FFFC);

    // Basic fetch, ack on the second FETCH cycle
    rst = 1'b0;
    tick();
    check("idle_memReq", {31'b0, memReq_a}, 32'd0);
    en = 1'b1;
    tick();
    check("f1_memReq", {31'b0, memReq_a}, 32'd1);
    check("f1_memAddr", memAddr_a, 32'h0);
    tick();
    check("f2_memReq", {31'b0, memReq_a}, 32'd1);
    memAck = 1'b1; memData = 32'h0050_0093;
    tick();
    check("f_valid", {31'b0, instrValid_a}, 32'd1);
    check("f_Op", {25'b0, Op_a}, 32'h13);
    check("f_rd", {27'b0, rd_a}, 32'd1);
    check("f_ipc", instrPC_a, 32'h0);
    check("f_hold_memReq", {31'b0, memReq_a}, 32'd0);
    memAck = 1'b0;
    tick();
    check("next_memAddr", memAddr_a, 32'h4);
    check("next_memReq", {31'b0, memReq_a}, 32'd1);
    check("wrap_memAddr_b", memAddr_b, 32'h0);
    check("wrap_ipc_b", instrPC_b, 32'hFFFF_FFFC);

    // Stall in HOLD for five cycles
    memAck = 1'b1; memData = 32'h0020_8133; stall = 1'b1;
    tick();
    memAck = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_valid", {31'b0, instrValid_a}, 32'd1);
      check("stall_instr", instr_a, 32'h0020_8133);
      check("stall_ipc", instrPC_a, 32'h4);
      check("stall_memReq", {31'b0, memReq_a}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check("consume_valid", {31'b0, instrValid_a}, 32'd0);
    check("consume_memReq", {31'b0, memReq_a}, 32'd1);
    check("consume_addr", memAddr_a, 32'h8);

    // Redirect wins over a same-edge ack
    memAck = 1'b1; memData = 32'hFFFF_FFFF; redirect = 1'b1; redirectPC = 32'h0000_0103;
    tick();
    check("redir_valid", {31'b0, instrValid_a}, 32'd0);
    check("redir_instr", instr_a, NOPW);
    check("redir_addr", memAddr_a, 32'h100);
    redirect = 1'b0; memAck = 1'b0;
    tick();
    memAck = 1'b1; memData = 32'h0000_006F;
    tick();
    check("redir_fetch_ipc", instrPC_a, 32'h100);
    check("redir_fetch_Op", {25'b0, Op_a}, 32'h6F);

    // Redirect wins over stall in HOLD
    memAck = 1'b0; stall = 1'b1;
    tick();
    redirect = 1'b1; redirectPC = 32'h0000_0200;
    tick();
    check("redir_hold_valid", {31'b0, instrValid_a}, 32'd0);
    check("redir_hold_addr", memAddr_a, 32'h200);
    redirect = 1'b0; stall = 1'b0;

    // en dropped during HOLD parks the unit after consume
    memAck = 1'b1; memData = 32'h0000_0513; stall = 1'b1;
    tick();
    memAck = 1'b0; en = 1'b0;
    tick();
    check("park_hold_valid", {31'b0, instrValid_a}, 32'd1);
    check("park_rd", {27'b0, rd_a}, 32'd10);
    stall = 1'b0;
    tick();
    check("park_valid", {31'b0, instrValid_a}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("park_memReq", {31'b0, memReq_a}, 32'd0);
    end
    en = 1'b1;
    tick();
    check("unpark_memReq", {31'b0, memReq_a}, 32'd1);
    check("unpark_addr", memAddr_a, 32'h204);

    // Back-to-back fetches, one instruction every two cycles
    memAck = 1'b1;
    for (int k = 0; k < 4; k++) begin
      memData = tbl[k];
      tick();
      check("b2b_valid", {31'b0, instrValid_a}, 32'd1);
      check("b2b_ipc", instrPC_a, 32'h204 + 32'(k) * 32'd4);
      check("b2b_instr", instr_a, tbl[k]);
      tick();
    end
    memAck = 1'b0;

    // Reset mid-fetch, then a late ack while parked
    check("pre_rst_memReq", {31'b0, memReq_a}, 32'd1);
    rst = 1'b1; en = 1'b0;
    #1;
    check("async_memReq", {31'b0, memReq_a}, 32'd0);
    check("async_addr", memAddr_a, 32'h0);
    tick();
    rst = 1'b0; memAck = 1'b1; memData = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("late_ack_valid", {31'b0, instrValid_a}, 32'd0);
      check("late_ack_instr", instr_a, NOPW);
      check("late_ack_memReq", {31'b0, memReq_a}, 32'd0);
    end
    memAck = 1'b0;

    // Redirect while parked, then fetch across the top of the address space
    redirect = 1'b1; redirectPC = 32'hFFFF_FFFF;
    tick();
    check("idle_redir_memReq", {31'b0, memReq_a}, 32'd0);
    check("idle_redir_addr", memAddr_a, 32'hFFFF_FFFC);
    redirect = 1'b0; en = 1'b1;
    tick();
    memAck = 1'b1; memData = 32'h0000_0037;
    tick();
    check("top_ipc", instrPC_a, 32'hFFFF_FFFC);
    check("top_wrap_addr", memAddr_a, 32'h0);
    memAck = 1'b0; en = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
